// File: rtl/ifetch_pkg.sv
// Shared state encoding and constants for the instruction fetch unit.
package ifetch_pkg;

  typedef enum logic [1:0] {
    StFetch,
    StStall,
    StDrop
  } ifetch_state_e;

  localparam logic [31:0] IfetchNop = 32'h0000_0000;
  localparam int unsigned DefaultPcStep = 4;

endpackage

// File: rtl/ifetch_skid.sv
// IF/ID pipeline slot backed by a one-entry skid buffer that absorbs decode back-pressure.
module ifetch_skid #(
  parameter int unsigned      Width    = 64,
  parameter logic [Width-1:0] ResetVal = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] data_i,
  input  logic             ready_i,
  input  logic             flush_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o
);

  logic             slot_valid_q, slot_valid_d;
  logic [Width-1:0] slot_q, slot_d;
  logic             skid_valid_q, skid_valid_d;
  logic [Width-1:0] skid_q, skid_d;

  always_comb begin
    slot_valid_d = slot_valid_q;
    slot_d       = slot_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;
    if (flush_i) begin
      slot_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      // A full skid implies a full slot; it refills the slot once decode drains it.
      if (ready_i) begin
        slot_d       = skid_q;
        skid_valid_d = 1'b0;
      end
    end else if (load_i) begin
      if (!slot_valid_q || ready_i) begin
        slot_d       = data_i;
        slot_valid_d = 1'b1;
      end else begin
        skid_d       = data_i;
        skid_valid_d = 1'b1;
      end
    end else if (slot_valid_q && ready_i) begin
      slot_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot_valid_q <= 1'b0;
      slot_q       <= ResetVal;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_q       <= slot_d;
      skid_valid_q <= skid_valid_d;
      skid_q       <= skid_d;
    end
  end

  assign valid_o = slot_valid_q;
  assign data_o  = slot_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: PC register, next-PC select and one-outstanding imem reads into IF/ID.
// Optional stall cycle counter output enabled by defining IFETCH_STALL_CNT_EN.
module inst_fetch_unit
  import ifetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       PC_STEP  = DefaultPcStep
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              ifid_valid,
  output logic [DATA_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0] ifid_pc_plus4,
  input  logic              ifid_ready
`ifdef IFETCH_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  localparam logic [ADDR_W-1:0] Step      = ADDR_W'(PC_STEP);
  localparam logic [ADDR_W-1:0] AlignMask = ~ADDR_W'(3);

  ifetch_state_e state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [ADDR_W-1:0] fetch_next;
  logic              pending;
  logic              load;
  logic              flush;
  logic [DATA_W+ADDR_W-1:0] slot_data;

  assign imem_req   = !rst && (state_q != StStall);
  assign imem_addr  = req_addr_q;
  assign pending    = imem_req && !imem_ack;
  assign fetch_next = req_addr_q + Step;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    load    = 1'b0;
    flush   = 1'b0;
    if (branch_taken) begin
      pc_d    = branch_addr & AlignMask;
      flush   = 1'b1;
      // An unanswered request must still complete at its old address before refetching.
      state_d = pending ? StDrop : StFetch;
    end else begin
      unique case (state_q)
        StFetch: begin
          if (imem_ack) begin
            pc_d = pc_q + Step;
            load = 1'b1;
            if (ifid_valid && !ifid_ready) begin
              state_d = StStall;
            end
          end
        end
        StStall: if (ifid_ready) state_d = StFetch;
        StDrop:  if (imem_ack) state_d = StFetch;
        default: state_d = StFetch;
      endcase
    end
    // The request address only moves once the bus is free.
    req_addr_d = pending ? req_addr_q : pc_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StFetch;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
    end
  end

  ifetch_skid #(
    .Width    (DATA_W + ADDR_W),
    .ResetVal ({DATA_W'(IfetchNop), {ADDR_W{1'b0}}})
  ) u_skid (
    .clk_i   (clk),
    .rst_i   (rst),
    .load_i  (load),
    .data_i  ({imem_rdata, fetch_next}),
    .ready_i (ifid_ready),
    .flush_i (flush),
    .valid_o (ifid_valid),
    .data_o  (slot_data)
  );

  assign ifid_instr    = slot_data[DATA_W+ADDR_W-1:ADDR_W];
  assign ifid_pc_plus4 = slot_data[ADDR_W-1:0];

`ifdef IFETCH_STALL_CNT_EN
  logic [31:0] stall_cnt_q;
  logic        stall_cycle;

  assign stall_cycle = (state_q == StStall) || (state_q == StDrop) || pending;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (stall_cycle && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a fetch-order scoreboard model checked every cycle.
module tb_inst_fetch_unit;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_ready = 1'b1;
`ifdef IFETCH_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr ^ K;

  inst_fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .branch_taken  (branch_taken),
    .branch_addr   (branch_addr),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .ifid_valid    (ifid_valid),
    .ifid_instr    (ifid_instr),
    .ifid_pc_plus4 (ifid_pc_plus4),
    .ifid_ready    (ifid_ready)
`ifdef IFETCH_STALL_CNT_EN
    ,
    .stall_cnt     (stall_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic a, input logic rdy, input logic br,
                       input logic [31:0] ba);
    rst          = r;
    imem_ack     = a;
    ifid_ready   = rdy;
    branch_taken = br;
    branch_addr  = ba;
    @(posedge clk);
    #1;
  endtask

  // Model: queue of delivered-but-unconsumed words {instr, pc+4}, plus the next fetch
  // address and the one request that may still be in flight.
  logic [63:0] q[$];
  logic [31:0] mpc = '0;
  logic [31:0] out_addr = '0;
  bit          out_valid = 0;
  bit          stale = 0;
  bit          model_on = 0;
  logic [31:0] mcnt = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (model_on) begin
        check("req", imem_req, 32'(!rst && (q.size() < 2)));
        if (imem_req) check("addr", imem_addr, out_valid ? out_addr : mpc);
        check("valid", ifid_valid, 32'(q.size() != 0));
        if (q.size() != 0) begin
          check("instr", ifid_instr, q[0][63:32]);
          check("pcp4", ifid_pc_plus4, q[0][31:0]);
        end
`ifdef IFETCH_STALL_CNT_EN
        check("stall_cnt", stall_cnt, mcnt);
`endif
      end
      if (rst) begin
        q.delete();
        mpc       = 32'h0;
        out_valid = 0;
        stale     = 0;
        mcnt      = '0;
        model_on  = 1;
      end else if (model_on) begin
        if ((q.size() == 2) || (imem_req && (!imem_ack || stale))) begin
          if (mcnt != 32'hFFFF_FFFF) mcnt++;
        end
        if (branch_taken) begin
          q.delete();
          mpc = branch_addr & 32'hFFFF_FFFC;
          if (imem_req && !imem_ack) begin
            out_valid = 1;
            out_addr  = imem_addr;
            stale     = 1;
          end else begin
            out_valid = 0;
            stale     = 0;
          end
        end else begin
          if (ifid_ready && (q.size() > 0)) void'(q.pop_front());
          if (imem_req && imem_ack) begin
            if (!stale) begin
              q.push_back({imem_rdata, imem_addr + 32'd4});
              mpc = imem_addr + 32'd4;
            end
            out_valid = 0;
            stale     = 0;
          end else if (imem_req) begin
            out_valid = 1;
            out_addr  = imem_addr;
          end
        end
      end
    end
  end

  initial begin
    // Reset
    drive(1, 0, 1, 0, 0);
    drive(1, 0, 1, 0, 0);
    check("rst_valid", ifid_valid, 0);
    check("rst_instr", ifid_instr, 0);
    check("rst_pcp4", ifid_pc_plus4, 0);
    check("rst_req", imem_req, 0);

    // Zero-wait stream
    drive(0, 1, 1, 0, 0);
    check("zw_valid", ifid_valid, 1);
    check("zw_pcp4_0", ifid_pc_plus4, 32'h4);
    check("zw_instr_0", ifid_instr, 32'hA5A5_0000);
    check("zw_addr_1", imem_addr, 32'h4);
    drive(0, 1, 1, 0, 0);
    check("zw_pcp4_1", ifid_pc_plus4, 32'h8);
    check("zw_addr_2", imem_addr, 32'h8);
    drive(0, 1, 1, 0, 0);
    check("zw_pcp4_2", ifid_pc_plus4, 32'hC);
    check("zw_instr_2", ifid_instr, 32'hA5A5_0008);

    // Wait states on the request at 0xC
    drive(0, 0, 1, 0, 0);
    check("ws_valid", ifid_valid, 0);
    check("ws_addr_a", imem_addr, 32'hC);
    drive(0, 0, 1, 0, 0);
    check("ws_addr_b", imem_addr, 32'hC);
    drive(0, 1, 1, 0, 0);
    check("ws_pcp4", ifid_pc_plus4, 32'h10);
    check("ws_addr_next", imem_addr, 32'h10);

    // Back-pressure: skid fills, request withheld, then drained in order
    drive(0, 1, 0, 0, 0);
    check("bp_req_0", imem_req, 0);
    check("bp_pcp4_hold", ifid_pc_plus4, 32'h10);
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    check("bp_req_2", imem_req, 0);
    drive(0, 1, 1, 0, 0);
    check("bp_pcp4_skid", ifid_pc_plus4, 32'h14);
    check("bp_req_resume", imem_req, 1);
    check("bp_addr_resume", imem_addr, 32'h14);
    drive(0, 1, 1, 0, 0);
    check("bp_pcp4_next", ifid_pc_plus4, 32'h18);

    // Branch with ack in the same cycle
    drive(0, 1, 1, 1, 32'h103);
    check("br_valid", ifid_valid, 0);
    check("br_addr", imem_addr, 32'h100);
    drive(0, 1, 1, 0, 0);
    check("br_pcp4", ifid_pc_plus4, 32'h104);
    check("br_instr", ifid_instr, 32'hA5A5_0100);

    // Branch while a request is pending
    drive(0, 0, 1, 1, 32'h200);
    check("drop_addr_a", imem_addr, 32'h104);
    check("drop_req", imem_req, 1);
    drive(0, 0, 1, 0, 0);
    check("drop_addr_b", imem_addr, 32'h104);
    drive(0, 1, 1, 0, 0);
    check("drop_valid", ifid_valid, 0);
    check("drop_addr_new", imem_addr, 32'h200);
    drive(0, 1, 1, 0, 0);
    check("drop_pcp4", ifid_pc_plus4, 32'h204);

    // PC wrap
    drive(0, 1, 1, 1, 32'hFFFF_FFFD);
    check("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
    drive(0, 1, 1, 0, 0);
    check("wrap_pcp4", ifid_pc_plus4, 32'h0);
    check("wrap_instr", ifid_instr, 32'h5A5A_FFFC);
    check("wrap_addr", imem_addr, 32'h0);

    // Reset while stalled with the skid full
    drive(0, 1, 0, 0, 0);
    check("rs_stall_req", imem_req, 0);
    drive(1, 0, 0, 0, 0);
    check("rs_valid", ifid_valid, 0);
    check("rs_req", imem_req, 0);
`ifdef IFETCH_STALL_CNT_EN
    check("rs_cnt", stall_cnt, 0);
`endif
    rst = 1'b0;
    #1;
    check("rs_req_after", imem_req, 1);
    check("rs_addr_after", imem_addr, 32'h0);
    drive(0, 1, 1, 0, 0);
    check("rs_pcp4", ifid_pc_plus4, 32'h4);

    // Mixed traffic checked by the model
    for (int i = 0; i < 400; i++) begin
      drive(0, ($urandom % 3) != 0, ($urandom % 4) != 0, ($urandom % 16) == 0, $urandom);
    end
    drive(0, 1, 1, 0, 0);
    drive(0, 0, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
Sequential consumer side of the instruction-address path in the InstructionFetch stage. It owns the PC register and selects the next PC: sequential PC+4, or the branch target when branch_taken is high. It drives one-outstanding-request reads to instruction memory and delivers fetched words into the IF/ID pipeline slot. Decode back-pressure is absorbed by a one-entry skid buffer.

Parameters:
ADDR_W, 32, PC/address width
DATA_W, 32, instruction width
RESET_PC, 32'h0000_0000, first fetch address after reset
PC_STEP, 4, sequential increment in bytes

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
branch_taken  in  1  PCSrc from EX; redirect fetch this cycle
branch_addr  in  ADDR_W  branch/jump target
imem_req  out  1  read request to instruction memory
imem_addr  out  ADDR_W  request address; held stable while imem_req && !imem_ack
imem_ack  in  1  read data valid; may assert in the same cycle as imem_req (zero-wait)
imem_rdata  in  DATA_W  instruction word, valid when imem_ack
ifid_valid  out  1  IF/ID slot holds a live instruction
ifid_instr  out  DATA_W  instruction in slot
ifid_pc_plus4  out  ADDR_W  fetch address + PC_STEP for that instruction
ifid_ready  in  1  decode consumes the slot this cycle when ifid_valid

Behaviour:
- Reset (rst high at edge): pc=RESET_PC, state=FETCH, imem_req=0 during the reset cycle, ifid_valid=0, ifid_instr=0 (NOP), ifid_pc_plus4=0, skid empty. The first request (addr RESET_PC) is issued in the cycle after rst deasserts.
- Priority at each edge: rst > branch_taken > imem_ack.
- FETCH state:
  - imem_req=1, imem_addr=req_addr. req_addr is registered and equals pc when the request starts.
  - On ack with the slot free or draining (!ifid_valid || ifid_ready): slot <= {rdata, req_addr+PC_STEP}; pc += PC_STEP; the next request starts in the next cycle.
  - On ack with slot full and !ifid_ready: skid <= {rdata, req_addr+PC_STEP}; pc += PC_STEP; go to STALL.
- STALL state:
  - imem_req=0.
  - When ifid_ready: slot <= skid, skid emptied, go to FETCH.
- DROP state:
  - Entered on branch_taken while a request is pending without ack.
  - imem_req stays 1 and imem_addr holds the old req_addr until ack.
  - The acked data is discarded; then go to FETCH using the new pc.
- branch_taken (any state):
  - pc <= {branch_addr[ADDR_W-1:2], 2'b00}.
  - ifid_valid <= 0; skid flushed.
  - If in FETCH without ack in the same cycle, go to DROP; otherwise go to FETCH.
  - An ack arriving in the same cycle as branch_taken is discarded.
- Arithmetic: PC increment is modulo 2^ADDR_W; 0xFFFF_FFFC wraps to 0x0.
- Ordering: instructions reach the slot in fetch order, each exactly once; no fetch is lost or duplicated.
- Slot consumption: when ifid_ready && ifid_valid and nothing new is loaded, ifid_valid <= 0. ifid_instr and ifid_pc_plus4 keep their last value.

Optional Feature:
IFETCH_STALL_CNT_EN
- Defined: adds output port stall_cnt [31:0], reset 0. It increments on each cycle that is in STALL, in DROP, or in FETCH with imem_req && !imem_ack. It saturates at 32'hFFFF_FFFF.
- Undefined: the port and the counter logic are absent; all other behaviour is identical.

Decomposition:
- Package ifetch_pkg:
  - state encoding (FETCH, STALL, DROP)
  - NOP constant 32'h0000_0000
  - default PC_STEP
- One natural sub-module, ifetch_skid: holds the IF/ID slot plus the one-entry skid buffer. It has load, ready and flush inputs and valid/data outputs.
- The FSM and PC logic stay in inst_fetch_unit.

Test Plan:
- Zero-wait stream: reset, imem_ack tied 1, ifid_ready=1, rdata=addr -> imem_addr 0x0,0x4,0x8 on consecutive cycles; ifid_pc_plus4 0x4,0x8,0xC one cycle later.
- Wait states: ack delayed 2 cycles on the request at 0x4 -> imem_addr held 0x4 for 3 cycles; exactly one instruction with ifid_pc_plus4=0x8.
- Back-pressure: zero-wait, ifid_ready=0 for 3 cycles from the 2nd instruction -> skid filled, imem_req=0 in STALL. On release, 0x4/0x8/0xC are delivered in order with no gaps or duplicates.
- Branch with ack in the same cycle: branch_taken, branch_addr=0x103 while fetching 0x8 -> next imem_addr=0x100, ifid_valid=0 next cycle, 0x8 data discarded.
- Branch while pending: ack for 0xC delayed 3 cycles, branch to 0x200 -> imem_addr stays 0xC until ack, data dropped, then imem_addr=0x200.
- Reset mid-STALL with skid full -> next cycle ifid_valid=0, imem_req=0; the following cycle imem_req=1 at RESET_PC. With IFETCH_STALL_CNT_EN defined, stall_cnt=0 after reset.
